contador_seq: RTL
=================

Name: contador_seq

Overview:
Command sequencer that drives the up/down/load counter (Contador) through its operacao/valor inputs. It accepts timed commands over a valid/ready handshake and buffers them in a small FIFO. Each command is applied for a programmed number of clock cycles, and the sequencer watches the counter's cont output to block wrap-around. It sits between the control logic or testbench and the counter instance, and is the only driver of the counter's operacao and valor.

Parameters:
DEPTH, 4, command FIFO depth (power of 2, >=2)
DUR_W, 4, width of the per-command duration field
SAT_EN, 1, 1 = abort inc/dec commands before counter wrap; 0 = allow wrap

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_op  in  2  00 hold, 01 increment, 10 decrement, 11 load
cmd_valor  in  6  load value (used for op 11)
cmd_dur  in  DUR_W  cycles to apply op; 0 treated as 1
flush  in  1  discard queue and active command
cont  in  6  counter output feedback
operacao  out  2  operation to counter
valor  out  6  load value to counter
busy  out  1  command active (state RUN)
done  out  1  one-cycle pulse, command finished normally
sat  out  1  one-cycle pulse, command cut by saturation
level  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- One clock. Reset is synchronous and active-low: clr_n low at a rising edge clears the FIFO (level=0), state=IDLE, op_reg=00, valor_reg=0, remaining=0, done=0, sat=0. With reset applied: operacao=00, valor=0, busy=0, cmd_ready=1. Reset mid-command abandons the command with no done/sat pulse.
- Handshake: a command is pushed at the rising edge where cmd_valid && cmd_ready. cmd_ready = (level != DEPTH), combinational from level only, never from cmd_valid. Commands offered while cmd_ready=0 are not taken; the source holds them.
- FIFO: circular, read/write pointers wrap modulo DEPTH. A push and a pop in the same cycle leave level unchanged. There is no push when full and no pop when empty.
- FSM states: IDLE, RUN.
  - IDLE: operacao=00. If level!=0, pop the head into op_reg/valor_reg/remaining (dur 0 -> 1; op 11 forced to 1) and go to RUN at that edge.
  - RUN: operacao=op_reg and valor=valor_reg, unless the limit condition holds. remaining decrements each cycle.
    - When remaining==1: assert done next cycle.
    - Then, if level!=0, pop the next command at the same edge (back-to-back, no idle cycle). Otherwise go to IDLE.
- Latency: a command pushed at edge N into an empty FIFO while IDLE is popped at edge N+1. operacao shows it from N+1 to N+1+dur.
- Limit (SAT_EN=1): the limit condition is combinational on cont.
  - Op 01 with cont==6'h3F, or op 10 with cont==6'h00, forces operacao=00 that cycle.
  - The command terminates at that edge: sat pulses next cycle, done does not, and the next command is popped or the FSM returns to IDLE.
  - SAT_EN=0: no check; the counter wraps (3F->00, 00->3F).
- flush: a synchronous clear of the FIFO and the active command, taking effect at the next edge. It goes to IDLE with no done/sat pulse.
  - flush has priority over a simultaneous push; the pushed command is dropped even though cmd_ready was 1.
  - flush while IDLE and empty has no effect.
- Output timing: valor is held at the last loaded value when not in RUN. operacao is 00 whenever busy=0.
- done and sat are registered and never high together.
- level is registered; busy = (state==RUN).

Test Plan:
- Reset then single load: clr_n=0 for 2 cycles, then push {11, 6'h23, dur 5} -> operacao=11 and valor=23 for exactly 1 cycle starting 1 cycle after push; done pulses next; busy returns 0; level 1->0.
- Up count: after load 23, push {01, -, 8} -> operacao=01 for 8 cycles, done once, counter ends at 6'h2B; dur=0 command -> 1 cycle.
- Back-to-back: push 4 commands {01,4},{10,2},{00,3},{01,1} with the FSM stalled by the first -> cmd_ready=0 when level=4; the ops run contiguously with no 00 gap; done pulses 4 times; total busy = 10 cycles.
- Saturation: load 3C, then push {01, -, 10} with SAT_EN=1 -> 3 cycles of 01, then operacao=00 once cont=3F; sat pulses; no done; cont holds at 3F. Load 02 then {10,-,5} -> stops at 00 with sat. With SAT_EN=0 -> cont wraps 3F->00.
- Flush: queue 3 commands, assert flush mid-RUN together with cmd_valid -> next cycle IDLE, level=0, operacao=00, no done/sat, the simultaneous push is dropped.
- Reset mid-run: clr_n=0 during a {01,-,15} command -> next edge all outputs at reset values, level=0, no pulse; a push after release runs normally.

Source files
------------

// File: rtl/contador_seq.sv
// contador_seq -- timed command sequencer for the up/down/load counter.
//
// Commands {op, valor, dur} arrive over a valid/ready handshake and are
// buffered in a circular FIFO. Each command drives the counter's
// operacao/valor inputs for dur cycles (dur 0 behaves as 1, load always
// lasts exactly 1 cycle). With SAT_EN set, an increment at 6'h3F or a
// decrement at 6'h00 is suppressed and the command is cut short so the
// counter never wraps.
//
// Ports:
//   clk        system clock, rising edge
//   clr_n      synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  FIFO can accept a command (depends on level only)
//   cmd_op     00 hold, 01 increment, 10 decrement, 11 load
//   cmd_valor  load value
//   cmd_dur    cycles to apply op (0 treated as 1)
//   flush      discard queued and active commands at the next edge
//   cont       counter output feedback
//   operacao   operation to the counter
//   valor      load value to the counter
//   busy       a command is active
//   done       1-cycle pulse, command ran its full duration
//   sat        1-cycle pulse, command cut by the wrap limit
//   level      FIFO occupancy
module contador_seq #(
  parameter int DEPTH  = 4,
  parameter int DUR_W  = 4,
  parameter bit SAT_EN = 1'b1,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [5:0]       cmd_valor,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             flush,
  input  logic [5:0]       cont,
  output logic [1:0]       operacao,
  output logic [5:0]       valor,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic [LW-1:0]    level
);

  typedef struct packed {
    logic [1:0]       op;
    logic [5:0]       valor;
    logic [DUR_W-1:0] dur;
  } cmd_t;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  cmd_t [DEPTH-1:0] fifo_q;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  cmd_t             cmd_in, head;
  logic             push, pop, fifo_empty;

  assign cmd_in     = '{op: cmd_op, valor: cmd_valor, dur: cmd_dur};
  assign head       = fifo_q[rd_ptr];
  assign fifo_empty = (level == '0);
  assign cmd_ready  = (level != LW'(DEPTH));
  // flush wins over a simultaneous push: the command is dropped even
  // though cmd_ready was high.
  assign push       = cmd_valid && cmd_ready && !flush;

  // Storage needs no reset: entries are only read when level says so.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= cmd_in;
  end

  // ---------------------------------------------------------------------
  // Active command registers
  // ---------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [1:0]       op_reg;
  logic [5:0]       valor_reg;
  logic [DUR_W-1:0] remaining;
  logic             at_limit, last_cyc;
  logic             fin_done, fin_sat;

  assign last_cyc = (remaining == DUR_W'(1));

  // Wrap guard looks at the live counter value, so the suppressed op is
  // removed in the very cycle the counter sits at its end value.
  generate
    if (SAT_EN) begin : g_sat
      assign at_limit = (state == RUN) &&
                        (((op_reg == OP_INC) && (cont == 6'h3F)) ||
                         ((op_reg == OP_DEC) && (cont == 6'h00)));
    end else begin : g_nosat
      logic unused_cont;
      assign unused_cont = ^cont;
      assign at_limit    = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // FSM: next state, pop and completion decisions
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    fin_done  = 1'b0;
    fin_sat   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (at_limit || last_cyc) begin
          // A cut command reports sat only, even on its last cycle.
          fin_sat  = at_limit;
          fin_done = !at_limit;
          // Chain straight into the next command when one is queued.
          if (!fifo_empty) pop = 1'b1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      pop       = 1'b0;
      fin_done  = 1'b0;
      fin_sat   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy     = (state == RUN);
    operacao = (busy && !at_limit) ? op_reg : OP_HOLD;
  end

  // valor tracks the last popped command even while idle.
  assign valor = valor_reg;

  // ---------------------------------------------------------------------
  // Datapath: pointers, level, command registers, status pulses
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      op_reg    <= OP_HOLD;
      valor_reg <= '0;
      remaining <= '0;
      done      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      done <= fin_done;
      sat  <= fin_sat;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        remaining <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
        if (pop) begin
          op_reg    <= head.op;
          valor_reg <= head.valor;
          // Loads are single-shot; a zero duration still runs once.
          remaining <= ((head.op == OP_LOAD) || (head.dur == '0)) ?
                       DUR_W'(1) : head.dur;
        end else if ((state == RUN) && (state_nxt == RUN)) begin
          remaining <= remaining - DUR_W'(1);
        end else begin
          remaining <= '0;
        end
      end
    end
  end

endmodule
